// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared types and constants for the counter sequencer
package counter_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_ENABLE = 3'd2,
      S_RUN    = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      ST_NONE  = 2'd0,
      ST_DONE  = 2'd1,
      ST_CARRY = 2'd2,
      ST_ABORT = 2'd3
   } status_e;

   localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/counter_seq_timer.sv
// rtl/counter_seq_timer.sv - trigger phase timer with period and pulse-width clamping
module counter_seq_timer
   import counter_seq_pkg::*;
#(
   parameter int CW = 32
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          clear_i,
   input  logic          run_i,
   input  logic [CW-1:0] period_i,
   input  logic [CW-1:0] pulse_w_i,
   output logic          period_end_o,
   output logic          trig_next_o
);

   localparam logic [CW-1:0] MIN_P = CW'(MIN_PERIOD);

   logic [CW-1:0] period_eff;
   logic [CW-1:0] pulse_w_min;
   logic [CW-1:0] pulse_w_eff;
   logic [CW-1:0] phase_q;
   logic [CW-1:0] phase_d;

   // Width is capped at period-1 so every period keeps at least one low cycle.
   always_comb begin
      period_eff  = (period_i < MIN_P) ? MIN_P : period_i;
      pulse_w_min = (pulse_w_i == '0) ? CW'(1) : pulse_w_i;
      pulse_w_eff = (pulse_w_min > (period_eff - CW'(1))) ? (period_eff - CW'(1)) : pulse_w_min;
   end

   assign period_end_o = (phase_q == (period_eff - CW'(1)));

   always_comb begin
      phase_d = phase_q;
      if (clear_i) begin
         phase_d = '0;
      end else if (run_i) begin
         phase_d = period_end_o ? '0 : (phase_q + CW'(1));
      end
   end

   // Trigger level for the phase the next cycle will be in, so the caller can register it.
   assign trig_next_o = (phase_d < pulse_w_eff);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - arm-driven sequencer for one counter's load, enable and trigger inputs
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int CW = 32
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          arm_i,
   input  logic          abort_i,
   input  logic          carry_i,
   input  logic [CW-1:0] START,
   input  logic [CW-1:0] NPULSES,
   input  logic [CW-1:0] PERIOD,
   input  logic [CW-1:0] PULSE_W,
   input  logic          STOP_ON_CARRY,
   output logic [CW-1:0] cnt_start_o,
   output logic          cnt_start_load_o,
   output logic          cnt_enable_o,
   output logic          cnt_trigger_o,
   output logic          busy_o,
   output logic          done_o,
   output logic [1:0]    status_o,
   output logic [CW-1:0] pulse_count_o
);

   state_e        state_q, state_d;
   status_e       status_q, status_d;
   logic [CW-1:0] start_q, start_d;
   logic [CW-1:0] npulses_q, npulses_d;
   logic [CW-1:0] period_q, period_d;
   logic [CW-1:0] pulse_w_q, pulse_w_d;
   logic          stop_q, stop_d;
   logic [CW-1:0] pulse_count_q, pulse_count_d;
   logic          load_q, load_d;
   logic          enable_q, enable_d;
   logic          trig_q, trig_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          carry_q, carry_d;
   logic          carry_prev_q, carry_prev_d;

   logic          period_end;
   logic          trig_next;
   logic          arm_go;
   logic          abort_go;
   logic          carry_stop;
   logic          run_end;

   assign carry_d      = carry_i;
   assign carry_prev_d = carry_q;

   assign arm_go     = (state_q == S_IDLE) && arm_i && !abort_i;
   assign abort_go   = (state_q != S_IDLE) && abort_i;
   assign carry_stop = (state_q == S_RUN) && stop_q && carry_q && !carry_prev_q;
   assign run_end    = (state_q == S_RUN) && period_end && (pulse_count_q >= npulses_q);

   counter_seq_timer #(
      .CW (CW)
   ) u_timer (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .clear_i      (state_q == S_ENABLE),
      .run_i        (state_q == S_RUN),
      .period_i     (period_q),
      .pulse_w_i    (pulse_w_q),
      .period_end_o (period_end),
      .trig_next_o  (trig_next)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (arm_i) state_d = S_LOAD;
            S_LOAD:   state_d = S_ENABLE;
            S_ENABLE: state_d = (npulses_q == '0) ? S_DONE : S_RUN;
            S_RUN:    if (carry_stop || run_end) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are computed from the next state and registered alongside it.
   always_comb begin
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      load_d = (state_d == S_LOAD);
      trig_d = (state_d == S_RUN) && trig_next;

      enable_d = enable_q;
      if (abort_i || (state_d == S_LOAD)) begin
         enable_d = 1'b0;
      end else if (state_d == S_ENABLE) begin
         enable_d = 1'b1;
      end

      status_d = status_q;
      if (abort_go) begin
         status_d = ST_ABORT;
      end else if (arm_go) begin
         status_d = ST_NONE;
      end else if (carry_stop) begin
         status_d = ST_CARRY;
      end else if (state_d == S_DONE) begin
         status_d = ST_DONE;
      end

      start_d   = start_q;
      npulses_d = npulses_q;
      period_d  = period_q;
      pulse_w_d = pulse_w_q;
      stop_d    = stop_q;
      if (arm_go) begin
         start_d   = START;
         npulses_d = NPULSES;
         period_d  = PERIOD;
         pulse_w_d = PULSE_W;
         stop_d    = STOP_ON_CARRY;
      end

      pulse_count_d = pulse_count_q;
      if (arm_go) begin
         pulse_count_d = '0;
      end else if (trig_d && !trig_q && (pulse_count_q != '1)) begin
         pulse_count_d = pulse_count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         status_q      <= ST_NONE;
         start_q       <= '0;
         npulses_q     <= '0;
         period_q      <= '0;
         pulse_w_q     <= '0;
         stop_q        <= 1'b0;
         pulse_count_q <= '0;
         load_q        <= 1'b0;
         enable_q      <= 1'b0;
         trig_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         carry_q       <= 1'b0;
         carry_prev_q  <= 1'b0;
      end else begin
         status_q      <= status_d;
         start_q       <= start_d;
         npulses_q     <= npulses_d;
         period_q      <= period_d;
         pulse_w_q     <= pulse_w_d;
         stop_q        <= stop_d;
         pulse_count_q <= pulse_count_d;
         load_q        <= load_d;
         enable_q      <= enable_d;
         trig_q        <= trig_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         carry_q       <= carry_d;
         carry_prev_q  <= carry_prev_d;
      end
   end

   assign cnt_start_o      = start_q;
   assign cnt_start_load_o = load_q;
   assign cnt_enable_o     = enable_q;
   assign cnt_trigger_o    = trig_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign status_o         = status_q;
   assign pulse_count_o    = pulse_count_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - randomized and directed bench for counter_sequencer
module tb_counter_sequencer;

   localparam int CW = 16;

   logic          clk_i = 1'b0;
   logic          reset_n_i = 1'b1;
   logic          arm_i = 1'b0;
   logic          abort_i = 1'b0;
   logic          carry_i = 1'b0;
   logic          STOP_ON_CARRY = 1'b0;
   logic [CW-1:0] START = '0;
   logic [CW-1:0] NPULSES = '0;
   logic [CW-1:0] PERIOD = '0;
   logic [CW-1:0] PULSE_W = '0;
   logic [CW-1:0] cnt_start_o;
   logic          cnt_start_load_o;
   logic          cnt_enable_o;
   logic          cnt_trigger_o;
   logic          busy_o;
   logic          done_o;
   logic [1:0]    status_o;
   logic [CW-1:0] pulse_count_o;

   always #5 clk_i = ~clk_i;

   counter_sequencer #(
      .CW (CW)
   ) dut (
      .clk_i            (clk_i),
      .reset_n_i        (reset_n_i),
      .arm_i            (arm_i),
      .abort_i          (abort_i),
      .carry_i          (carry_i),
      .START            (START),
      .NPULSES          (NPULSES),
      .PERIOD           (PERIOD),
      .PULSE_W          (PULSE_W),
      .STOP_ON_CARRY    (STOP_ON_CARRY),
      .cnt_start_o      (cnt_start_o),
      .cnt_start_load_o (cnt_start_load_o),
      .cnt_enable_o     (cnt_enable_o),
      .cnt_trigger_o    (cnt_trigger_o),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .status_o         (status_o),
      .pulse_count_o    (pulse_count_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_edge   = 0;
   int rise_q[$];
   int done_q[$];
   int load_q[$];
   int hi_cnt   = 0;
   bit prev_trig = 1'b0;

   // Reference: a sequence armed at edge k is described by the offset t = n - k.
   bit            m_active = 1'b0;
   int            m_k, m_end, m_p, m_w;
   bit            m_stop, m_carry_end;
   bit            m_en = 1'b0;
   int            m_status = 0;
   int            m_count = 0;
   logic [CW-1:0] m_start = '0;
   bit            c1 = 1'b0;
   bit            c2 = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, n_edge);
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic model_edge(input int n);
      int  tp, t, pn;
      bit  rise_prev;
      rise_prev = c1 && !c2;
      if (!reset_n_i) begin
         m_active = 1'b0; m_en = 1'b0; m_status = 0; m_count = 0; m_start = '0;
         c1 = 1'b0; c2 = 1'b0;
         return;
      end
      if (abort_i) begin
         if (m_active) begin
            m_active = 1'b0;
            m_status = 3;
         end
         m_en = 1'b0;
      end else if (m_active) begin
         tp = n - 1 - m_k;
         t  = n - m_k;
         if (m_stop && rise_prev && tp >= 2 && tp < m_end) begin
            m_end       = tp + 1;
            m_carry_end = 1'b1;
         end
         if (t == 1) m_en = 1'b1;
         if (t == m_end) m_status = m_carry_end ? 2 : 1;
         else if (t > m_end) m_active = 1'b0;
         else if (t >= 2 && ((t - 2) % m_p) == 0 && m_count < (1 << CW) - 1) m_count++;
      end else if (arm_i) begin
         m_active    = 1'b1;
         m_k         = n;
         pn          = int'(NPULSES);
         m_p         = (int'(PERIOD) < 2) ? 2 : int'(PERIOD);
         m_w         = (int'(PULSE_W) < 1) ? 1 : int'(PULSE_W);
         if (m_w > m_p - 1) m_w = m_p - 1;
         m_stop      = STOP_ON_CARRY;
         m_carry_end = 1'b0;
         m_end       = 2 + pn * m_p;
         m_count     = 0;
         m_status    = 0;
         m_start     = START;
         m_en        = 1'b0;
      end
      c2 = c1;
      c1 = carry_i;
   endtask

   initial begin
      int  t;
      bit  e_busy, e_done, e_load, e_trig;
      forever begin
         @(posedge clk_i);
         n_edge++;
         model_edge(n_edge);
         #1;
         t      = n_edge - m_k;
         e_busy = m_active;
         e_load = m_active && (t == 0);
         e_done = m_active && (t == m_end);
         e_trig = m_active && (t >= 2) && (t < m_end) && (((t - 2) % m_p) < m_w);
         chk("ctl", {busy_o, done_o, cnt_start_load_o, cnt_enable_o, cnt_trigger_o},
             {e_busy, e_done, e_load, m_en, e_trig});
         chk("status", status_o, m_status);
         chk("count", pulse_count_o, m_count);
         chk("start", cnt_start_o, m_start);
         if (cnt_trigger_o && !prev_trig) rise_q.push_back(n_edge);
         if (cnt_trigger_o) hi_cnt++;
         if (done_o) done_q.push_back(n_edge);
         if (cnt_start_load_o) load_q.push_back(n_edge);
         prev_trig = cnt_trigger_o;
      end
   end

   task automatic arm_seq(input logic [CW-1:0] s, input logic [CW-1:0] n, input logic [CW-1:0] p,
                          input logic [CW-1:0] w, input logic stop, output int k);
      @(negedge clk_i);
      START = s; NPULSES = n; PERIOD = p; PULSE_W = w; STOP_ON_CARRY = stop;
      arm_i = 1'b1;
      k = n_edge + 1;
      rise_q.delete(); done_q.delete(); load_q.delete(); hi_cnt = 0;
      @(negedge clk_i);
      arm_i = 1'b0;
   endtask

   task automatic wait_edge(input int e);
      while (n_edge < e) @(negedge clk_i);
   endtask

   task automatic check_basic(input string tag, input int k);
      chk({tag, "_load"}, qget(load_q, 0), k);
      chk({tag, "_nrise"}, rise_q.size(), 3);
      chk({tag, "_rise0"}, qget(rise_q, 0), k + 2);
      chk({tag, "_rise1"}, qget(rise_q, 1), k + 7);
      chk({tag, "_rise2"}, qget(rise_q, 2), k + 12);
      chk({tag, "_high"}, hi_cnt, 6);
      chk({tag, "_done"}, qget(done_q, 0), k + 17);
      chk({tag, "_status"}, status_o, 1);
      chk({tag, "_count"}, pulse_count_o, 3);
      chk({tag, "_start"}, cnt_start_o, 10);
   endtask

   initial begin
      int k;
      #1 reset_n_i = 1'b0;
      #1 chk("reset", {cnt_start_o, cnt_start_load_o, cnt_enable_o, cnt_trigger_o, busy_o,
                       done_o, status_o, pulse_count_o}, 0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      repeat (2) @(negedge clk_i);

      // Nominal train; registers are scrambled mid-sequence and must be ignored.
      arm_seq(16'd10, 16'd3, 16'd5, 16'd2, 1'b0, k);
      START = 16'd99; NPULSES = 16'd7; PERIOD = 16'd9; PULSE_W = 16'd4;
      wait_edge(k + 19);
      check_basic("t1", k);
      chk("t1_enable", cnt_enable_o, 1);

      arm_seq(16'd5, 16'd0, 16'd5, 16'd2, 1'b0, k);
      wait_edge(k + 5);
      chk("t2_nrise", rise_q.size(), 0);
      chk("t2_done", qget(done_q, 0), k + 2);
      chk("t2_count", pulse_count_o, 0);

      arm_seq(16'd5, 16'd2, 16'd1, 16'd7, 1'b0, k);
      wait_edge(k + 8);
      chk("t3_rise0", qget(rise_q, 0), k + 2);
      chk("t3_rise1", qget(rise_q, 1), k + 4);
      chk("t3_high", hi_cnt, 2);
      chk("t3_done", qget(done_q, 0), k + 6);

      arm_seq(16'd3, 16'd100, 16'd4, 16'd3, 1'b1, k);
      wait_edge(k + 14);
      carry_i = 1'b1;
      @(negedge clk_i);
      carry_i = 1'b0;
      wait_edge(k + 20);
      chk("t4_done", qget(done_q, 0), k + 16);
      chk("t4_status", status_o, 2);
      chk("t4_count", pulse_count_o, 4);
      chk("t4_high", hi_cnt, 11);

      arm_seq(16'd1, 16'd5, 16'd3, 16'd1, 1'b0, k);
      wait_edge(k + 5);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      chk("t5_state", {busy_o, cnt_enable_o, cnt_trigger_o, done_o}, 0);
      chk("t5_status", status_o, 3);
      chk("t5_count", pulse_count_o, 2);
      arm_seq(16'd2, 16'd5, 16'd3, 16'd1, 1'b0, k);
      wait_edge(k + 3);
      arm_i = 1'b1; abort_i = 1'b1;
      @(negedge clk_i);
      arm_i = 1'b0; abort_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("t5b_state", {busy_o, cnt_enable_o}, 0);
      chk("t5b_status", status_o, 3);
      chk("t5b_loads", load_q.size(), 1);
      chk("t5b_dones", done_q.size(), 0);
      arm_seq(16'd3, 16'd1, 16'd2, 16'd1, 1'b0, k);
      wait_edge(k + 6);
      chk("t5c_done", qget(done_q, 0), k + 4);
      chk("t5c_enable", cnt_enable_o, 1);
      arm_i = 1'b1; abort_i = 1'b1;
      @(negedge clk_i);
      arm_i = 1'b0; abort_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("t5c_idle", {busy_o, cnt_enable_o}, 0);
      chk("t5c_status", status_o, 1);
      chk("t5c_loads", load_q.size(), 1);

      arm_seq(16'd7, 16'd4, 16'd4, 16'd2, 1'b0, k);
      wait_edge(k + 5);
      @(posedge clk_i);
      #3 reset_n_i = 1'b0;
      #1 chk("t6_async", {cnt_start_o, cnt_start_load_o, cnt_enable_o, cnt_trigger_o, busy_o,
                          done_o, status_o, pulse_count_o}, 0);
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
      arm_seq(16'd10, 16'd3, 16'd5, 16'd2, 1'b0, k);
      wait_edge(k + 19);
      check_basic("t6", k);

      repeat (900) begin
         @(negedge clk_i);
         arm_i         = ($urandom_range(0, 4) == 0);
         abort_i       = ($urandom_range(0, 36) == 0);
         carry_i       = ($urandom_range(0, 2) == 0);
         STOP_ON_CARRY = 1'($urandom_range(0, 1));
         START         = 16'($urandom);
         NPULSES       = 16'($urandom_range(0, 5));
         PERIOD        = 16'($urandom_range(0, 6));
         PULSE_W       = 16'($urandom_range(0, 7));
      end
      @(negedge clk_i);
      arm_i = 1'b0; abort_i = 1'b0; carry_i = 1'b0;
      repeat (40) @(negedge clk_i);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
